// File: rtl/cnt_delta_capture.sv
// Interval capture against the shared cntr timebase.
// Each rising edge of the asynchronous event input takes a timestamp from
// Q_in. From the second event onward, the block reports the modular
// difference from the previous timestamp through a valid/ready register.
// A result that arrives while the register still holds an unread one is
// dropped, and the dropped result sets a sticky overrun flag.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no reference timestamp; the next event only arms
// ST_ARMED | last_ts holds a valid reference; each event yields a delta

module cnt_delta_capture #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] Q_in,
    input  logic         evt_in,
    input  logic         delta_ready,
    input  logic         ovr_clr,
    output logic [N-1:0] delta,
    output logic         delta_valid,
    output logic         overrun,
    output logic         armed
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_prev_q, s_prev_d;
    logic [N-1:0]           last_ts_q, last_ts_d;
    logic [N-1:0]           delta_q, delta_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d;

    logic                   evt_edge;
    logic [N-1:0]           diff;
    logic                   slot_free;

    assign evt_edge  = sync_q[SYNC_STAGES-1] & ~s_prev_q;
    // Modular subtraction handles counter wrap without any special case.
    assign diff      = Q_in - last_ts_q;
    // The slot is free if it is empty, or if it is being drained on this edge.
    assign slot_free = ~valid_q | delta_ready;

    // Synchronizer shift and edge-history next values.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], evt_in};
        s_prev_d = sync_q[SYNC_STAGES-1];
    end

    // Next state, timestamp, output register and overrun flag.
    always_comb begin
        state_d   = state_q;
        last_ts_d = last_ts_q;
        delta_d   = delta_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;

        if (valid_q && delta_ready) begin
            valid_d = 1'b0;
        end

        if (ovr_clr) begin
            ovr_d = 1'b0;
        end

        if (evt_edge) begin
            // The reference always advances, even when the result is dropped.
            last_ts_d = Q_in;
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (slot_free) begin
                        delta_d = diff;
                        valid_d = 1'b1;
                    end else begin
                        // A drop overrides a simultaneous clear.
                        ovr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // All state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sync_q    <= '0;
            s_prev_q  <= 1'b0;
            last_ts_q <= '0;
            delta_q   <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            s_prev_q  <= s_prev_d;
            last_ts_q <= last_ts_d;
            delta_q   <= delta_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign delta       = delta_q;
    assign delta_valid = valid_q;
    assign overrun     = ovr_q;
    assign armed       = (state_q == ST_ARMED);

endmodule

// File: tb/tb_cnt_delta_capture.sv
// Bench for cnt_delta_capture (N=4, S=2, 60 ns clock).
// Q_in is a free-running counter that advances on every falling edge.
// A table of capture points covers the basic, wrap and full-period cases.
// Hand-written sequences cover overrun, clear, load-with-drain and reset.
// Every transfer is checked against a queue of expected deltas.

module tb_cnt_delta_capture;

    localparam int N = 4;
    localparam int S = 2;

    logic         clk;
    logic         reset;
    logic [N-1:0] q_in;
    logic         evt_in;
    logic         delta_ready;
    logic         ovr_clr;
    logic [N-1:0] delta;
    logic         delta_valid;
    logic         overrun;
    logic         armed;

    int checks;
    int errors;
    int sb_q[$];

    typedef struct {
        logic [N-1:0] cap_q;
        logic         exp_valid;
        logic [N-1:0] exp_delta;
    } vec_t;

    vec_t vecs[7];

    cnt_delta_capture #(.N(N), .SYNC_STAGES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .Q_in        (q_in),
        .evt_in      (evt_in),
        .delta_ready (delta_ready),
        .ovr_clr     (ovr_clr),
        .delta       (delta),
        .delta_valid (delta_valid),
        .overrun     (overrun),
        .armed       (armed)
    );

    initial clk = 1'b0;
    always #30 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the timebase: falling edge, then the counter advances.
    task automatic step();
        @(negedge clk);
        q_in = q_in + 1'b1;
    endtask

    // Pulse evt_in so that the capture edge sees Q_in == t.
    // Returns at the falling edge where Q_in == t-1; capture follows one step later.
    task automatic capture_at(input logic [N-1:0] t);
        logic [N-1:0] pre;
        int guard;
        pre = t - 4'd2;
        guard = 0;
        while (q_in != pre && guard < 40) begin
            step();
            guard++;
        end
        if (guard >= 40) chk("capture_at_timeout", guard, 0);
        evt_in = 1'b1;
        step();
        evt_in = 1'b0;
    endtask

    task automatic chk_all_clear(input string tag);
        chk({tag, "_delta"}, delta, 0);
        chk({tag, "_valid"}, delta_valid, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_armed"}, armed, 0);
    endtask

    // Transfer monitor: inputs settle at the falling edge, so at +1 the
    // values here are what the next rising edge will see.
    initial begin
        int exp;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && delta_valid && delta_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_transfer", delta, -1);
                end else begin
                    exp = sb_q.pop_front();
                    chk("sb_delta", delta, exp);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{cap_q: 4'd3,  exp_valid: 1'b0, exp_delta: 4'd0};
        vecs[1] = '{cap_q: 4'd9,  exp_valid: 1'b1, exp_delta: 4'd6};
        vecs[2] = '{cap_q: 4'd13, exp_valid: 1'b1, exp_delta: 4'd4};
        vecs[3] = '{cap_q: 4'd2,  exp_valid: 1'b1, exp_delta: 4'd5};
        vecs[4] = '{cap_q: 4'd6,  exp_valid: 1'b1, exp_delta: 4'd4};
        vecs[5] = '{cap_q: 4'd6,  exp_valid: 1'b1, exp_delta: 4'd0};
        vecs[6] = '{cap_q: 4'd4,  exp_valid: 1'b1, exp_delta: 4'd14};

        reset       = 1'b1;
        q_in        = '0;
        evt_in      = 1'b0;
        delta_ready = 1'b1;
        ovr_clr     = 1'b0;

        // Reset held while the event input toggles.
        for (int i = 0; i < 6; i++) begin
            step();
            evt_in = ~evt_in;
            #2;
            chk_all_clear("rst_hold");
        end
        step();
        evt_in = 1'b0;
        step();
        reset = 1'b0;

        // Table: first entry only arms, the rest each produce one result.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_valid) sb_q.push_back(int'(vecs[i].exp_delta));
            capture_at(vecs[i].cap_q);
            step();
            chk($sformatf("vec%0d_pre_valid", i), delta_valid, 0);
            step();
            chk($sformatf("vec%0d_armed", i), armed, 1);
            chk($sformatf("vec%0d_valid", i), delta_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) chk($sformatf("vec%0d_delta", i), delta, vecs[i].exp_delta);
            step();
            chk($sformatf("vec%0d_valid_one_cycle", i), delta_valid, 0);
        end

        // Overrun: one drained result, then intervals 4 (kept) and 7 (dropped).
        sb_q.push_back(6);
        capture_at(4'd10);
        step();
        step();
        chk("ovr_e1_valid", delta_valid, 1);
        step();
        chk("ovr_e1_drained", delta_valid, 0);
        delta_ready = 1'b0;
        sb_q.push_back(4);
        capture_at(4'd14);
        step();
        step();
        chk("ovr_e2_delta", delta, 4);
        chk("ovr_e2_overrun", overrun, 0);
        capture_at(4'd5);
        step();
        step();
        chk("ovr_e3_delta_held", delta, 4);
        chk("ovr_e3_valid", delta_valid, 1);
        chk("ovr_e3_overrun", overrun, 1);
        delta_ready = 1'b1;
        step();
        chk("ovr_drain_valid", delta_valid, 0);
        chk("ovr_drain_delta_kept", delta, 4);
        chk("ovr_sticky", overrun, 1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovr_clr", overrun, 0);

        // Clear and drop on the same edge: the drop wins.
        delta_ready = 1'b0;
        sb_q.push_back(4);
        capture_at(4'd9);
        step();
        step();
        chk("clr_drop_load_valid", delta_valid, 1);
        capture_at(4'd15);
        step();
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("clr_drop_overrun", overrun, 1);
        chk("clr_drop_delta_held", delta, 4);

        // Load and drain on the same edge: new value replaces, valid stays.
        sb_q.push_back(6);
        capture_at(4'd5);
        step();
        delta_ready = 1'b1;
        step();
        chk("load_drain_valid", delta_valid, 1);
        chk("load_drain_delta", delta, 6);
        step();
        chk("load_drain_empty", delta_valid, 0);

        // Reset in the middle of a pending result.
        delta_ready = 1'b0;
        capture_at(4'd11);
        step();
        step();
        chk("pre_rst_valid", delta_valid, 1);
        chk("pre_rst_armed", armed, 1);
        #7;
        reset = 1'b1;
        #1;
        chk_all_clear("rst_mid");
        step();
        reset = 1'b0;
        delta_ready = 1'b1;
        capture_at(4'd2);
        step();
        step();
        chk("post_rst_rearm", armed, 1);
        chk("post_rst_no_result", delta_valid, 0);
        sb_q.push_back(7);
        capture_at(4'd9);
        step();
        step();
        chk("post_rst_valid", delta_valid, 1);
        chk("post_rst_delta", delta, 7);
        step();
        chk("post_rst_drained", delta_valid, 0);

        step();
        chk("sb_all_consumed", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnt_delta_capture.md
# cnt_delta_capture

Downstream consumer of the free-running `cntr` count. Samples the counter value on each rising edge of an asynchronous event input and reports the elapsed count between consecutive events (modulo 2^N) through a valid/ready output register. Unread results are never overwritten; instead, a sticky overrun flag records each dropped result. Intended for period and interval measurement, with `cntr` acting as the shared timebase.

## Interface
- `N`, default 4: width of the count input and of the delta output. Must match the `cntr` width.
- `SYNC_STAGES`, default 2: number of synchronizer flops on `evt_in`. Legal range is 2 or more.

- `clk`  input  1: single clock, shared with `cntr`.
- `reset`  input  1: asynchronous, active-high reset.
- `Q_in`  input  N: free-running count from `cntr.Q`. Same clock domain, used as is.
- `evt_in`  input  1: asynchronous event. Its rising edge is the measured event.
- `delta_ready`  input  1: consumer is ready to accept `delta`.
- `ovr_clr`  input  1: synchronous, one-cycle clear of `overrun`.
- `delta`  output  N: interval between the last two events, in counts.
- `delta_valid`  output  1: `delta` holds an unconsumed result.
- `overrun`  output  1: sticky flag. At least one result was dropped.
- `armed`  output  1: a reference timestamp is held (state is ARMED).

## Operation
- **Synchronizer.** `evt_in` passes through a `SYNC_STAGES`-flop chain `s[0..S-1]`, then one history flop `s_prev`.
  - `edge = s[S-1] & ~s_prev`.
  - Every event needs at least one sampled low cycle between highs. Pulses shorter than one `clk` period may be missed; this is accepted behaviour.
- **States:** IDLE (no reference timestamp) and ARMED. `armed` is high exactly when state is ARMED.
- **IDLE:** on `edge`, set `last_ts <= Q_in` and move to ARMED. No result is produced.
- **ARMED:** on `edge`:
  - Compute `d = Q_in - last_ts`, truncated to N bits (mod 2^N).
  - Set `last_ts <= Q_in`. This happens even when the result is dropped.
  - Output slot free, meaning `!delta_valid` or `delta_valid & delta_ready` this cycle: set `delta <= d` and `delta_valid <= 1`.
  - Output slot busy, meaning `delta_valid & !delta_ready`: drop `d`, set `overrun <= 1`, and leave `delta` unchanged.
- **Handshake:**
  - A transfer happens on a rising `clk` where `delta_valid & delta_ready`.
  - Without a new load, `delta_valid` clears on that edge and `delta` keeps its last value.
  - While `delta_valid & !delta_ready`, `delta` is held stable.
- **Arithmetic.** Wrap-around is handled implicitly by the modular subtraction.
  - Intervals of 2^N counts or more alias, and this is not detected.
  - An interval of exactly 2^N reports 0.
- **Overrun.**
  - Set only by a dropped result.
  - Cleared by `ovr_clr` or `reset`.
  - If set and `ovr_clr` occur on the same cycle, set wins.
- **Reset** (asynchronous, any time, including mid-handshake):
  - Cleared immediately: all synchronizer flops, `s_prev`, `last_ts`, `delta`, `delta_valid`, `overrun`.
  - State returns to IDLE.
  - After `reset` is released, the next event only re-arms the block.

## Timing
- Reset values: `delta = 0`, `delta_valid = 0`, `overrun = 0`, `armed = 0`.
- Edge latency:
  - `evt_in` first sampled high at clock edge k.
  - `edge` is high during the cycle after edge k+S-1.
  - Capture happens at edge k+S, using the `Q_in` value present just before edge k+S.
- The capture offset is identical for every event, so it cancels out in `d`.
- `delta_valid` rises at edge k+S, which is S+1 edges after first sampling.
- Throughput: one result per event. The fastest legal event rate is once every 2 cycles after synchronization.
- Load and drain on the same edge: the new `d` replaces the transferred value, and `delta_valid` stays 1.
- `ovr_clr` takes effect on the next edge.

## Test plan
- **Reset:** hold `reset=1` with `evt_in` toggling. Required: `delta=0`, `delta_valid=0`, `overrun=0`, `armed=0` throughout; each clears immediately on `reset` assertion, even mid-cycle.
- **Arm only:** after reset, one `evt_in` pulse, `delta_ready=1`. Required: `armed=1` at S+1 edges, `delta_valid` stays 0.
- **Basic interval** (N=4, S=2, clock half-period 30 ns):
  - Captures occur at `Q_in` = 3, then at `Q_in` = 9.
  - Required: `delta=6` with `delta_valid=1` for exactly one cycle while `delta_ready=1`.
- **Wrap:** captures at `Q_in` = 13, then at `Q_in` = 2. Required: `delta=5`.
- **Overrun:**
  - Set `delta_ready=0` and apply three events whose successive intervals are 4 and 7.
  - Required: `delta=4` held, `delta_valid=1`, and `overrun=1` after the third event.
  - Raise `delta_ready`: the block transfers 4, then `delta_valid=0`.
  - Pulse `ovr_clr`: `overrun=0` on the next edge.
  - Pulse `ovr_clr` on the same cycle as a drop: `overrun` stays 1.
- **Reset mid-operation:**
  - Assert `reset` while `delta_valid=1` and `armed=1`, then release it.
  - Next event: `armed=1` and no result.
  - The event after that: `delta` equals the `Q_in` difference between the two post-reset captures.
